// File: rtl/fetch_pkg.sv
// Shared types and constants for the pipelined instruction-fetch unit.
// Buffer entries carry the package widths; fetch_pipe ADDR_W/DATA_W must not exceed them.
package fetch_pkg;

   localparam int unsigned FETCH_ADDR_W = 32;
   localparam int unsigned FETCH_DATA_W = 32;
   localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = 32'h0000_3000;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      HALT  = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [FETCH_ADDR_W-1:0] pc;
      logic [FETCH_DATA_W-1:0] instr;
      logic                    exc;
   } fetch_entry_t;

   function automatic int unsigned fetch_cnt_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of fetch entries with flush and one-entry load-on-flush.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_flush,
   input  logic                   i_load,
   input  fetch_entry_t           i_load_entry,
   input  logic                   i_push,
   input  fetch_entry_t           i_push_entry,
   input  logic                   i_pop,
   output fetch_entry_t           o_head,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   fetch_entry_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;

   // Storage, pointers and occupancy; flush wins over push/pop.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_rd_ptr <= '0;
         if (i_load) begin
            r_mem[0] <= i_load_entry;
            r_wr_ptr <= PTR_W'(1);
            r_count  <= CNT_W'(1);
         end else begin
            r_wr_ptr <= '0;
            r_count  <= '0;
         end
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/fetch_pipe.sv
// Pipelined instruction fetch: PC sequencer, credit-limited memory requests,
// in-order responses into a prefetch buffer drained by decode.
module fetch_pipe
   import fetch_pkg::*;
#(
   parameter int unsigned        ADDR_W    = FETCH_ADDR_W,
   parameter int unsigned        DATA_W    = FETCH_DATA_W,
   parameter logic [ADDR_W-1:0]  RESET_PC  = FETCH_RESET_PC,
   parameter int unsigned        BUF_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [DATA_W-1:0] imem_rsp_data,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [DATA_W-1:0] id_instr,
   output logic [ADDR_W-1:0] id_pc,
   output logic [ADDR_W-1:0] id_pc4,
   output logic              id_exc_adel
);

   localparam int unsigned CNT_W = fetch_cnt_w(BUF_DEPTH);

   fetch_state_e      r_state;
   logic [ADDR_W-1:0] r_fetch_pc;
   logic [ADDR_W-1:0] r_rsp_pc;
   logic [CNT_W-1:0]  r_out_cnt;
   logic [CNT_W-1:0]  r_drop_cnt;

   logic [CNT_W-1:0]  w_occ;
   logic [CNT_W:0]    w_credit_used;
   logic              w_empty;
   logic              w_misaligned;
   logic              w_req_fire;
   logic              w_rsp_keep;
   logic              w_pop;
   fetch_entry_t      w_head;
   fetch_entry_t      w_push_entry;
   fetch_entry_t      w_load_entry;

   // Handshake gating; in-flight plus buffered entries never exceed BUF_DEPTH.
   always_comb begin
      w_misaligned  = (redirect_pc[1:0] != 2'b00);
      w_credit_used = {1'b0, r_out_cnt} + {1'b0, w_occ};
      if (reset && (r_state == FETCH) && !redirect_valid &&
          (w_credit_used < (CNT_W+1)'(BUF_DEPTH))) begin
         imem_req_valid = 1'b1;
      end else begin
         imem_req_valid = 1'b0;
      end
      if (!w_empty && !redirect_valid) begin
         id_valid = 1'b1;
      end else begin
         id_valid = 1'b0;
      end
      w_req_fire   = imem_req_valid && imem_req_ready;
      w_rsp_keep   = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
      w_pop        = id_valid && id_ready;
      w_push_entry = '{pc: FETCH_ADDR_W'(r_rsp_pc), instr: FETCH_DATA_W'(imem_rsp_data), exc: 1'b0};
      w_load_entry = '{pc: FETCH_ADDR_W'(redirect_pc), instr: '0, exc: 1'b1};
   end

   // PC sequencing and credit accounting; r_rsp_pc is the PC of the next kept response.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_pc <= RESET_PC;
         r_rsp_pc   <= RESET_PC;
         r_out_cnt  <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_out_cnt <= r_out_cnt + CNT_W'(w_req_fire) - CNT_W'(imem_rsp_valid);
         if (redirect_valid) begin
            r_drop_cnt <= r_out_cnt - CNT_W'(imem_rsp_valid);
            if (!w_misaligned) begin
               r_fetch_pc <= redirect_pc;
               r_rsp_pc   <= redirect_pc;
            end
         end else begin
            if (w_req_fire) begin
               r_fetch_pc <= r_fetch_pc + ADDR_W'(32'd4);
            end
            if (imem_rsp_valid && (r_drop_cnt != '0)) begin
               r_drop_cnt <= r_drop_cnt - CNT_W'(1);
            end
            if (w_rsp_keep) begin
               r_rsp_pc <= r_rsp_pc + ADDR_W'(32'd4);
            end
         end
      end
   end

   // FETCH/HALT control: only a redirect changes state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= FETCH;
      end else if (redirect_valid) begin
         r_state <= w_misaligned ? HALT : FETCH;
      end else begin
         r_state <= r_state;
      end
   end

   fetch_fifo #(
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .i_clk        (clk),
      .i_rst_n      (reset),
      .i_flush      (redirect_valid),
      .i_load       (w_misaligned),
      .i_load_entry (w_load_entry),
      .i_push       (w_rsp_keep),
      .i_push_entry (w_push_entry),
      .i_pop        (w_pop),
      .o_head       (w_head),
      .o_empty      (w_empty),
      .o_count      (w_occ)
   );

   assign imem_req_addr = r_fetch_pc;
   assign id_instr      = DATA_W'(w_head.instr);
   assign id_pc         = ADDR_W'(w_head.pc);
   assign id_pc4        = ADDR_W'(w_head.pc) + ADDR_W'(32'd4);
   assign id_exc_adel   = w_head.exc;

endmodule

// File: tb/tb_fetch_pipe.sv
// Directed bench for fetch_pipe: vector table plus hand-written multi-cycle sequences
// against a latency-configurable in-order memory model.
module tb_fetch_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc4;
   logic        id_exc_adel;

   always #5 clk = ~clk;

   fetch_pipe #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .RESET_PC  (32'h0000_3000),
      .BUF_DEPTH (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_pc4         (id_pc4),
      .id_exc_adel    (id_exc_adel)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   typedef struct {
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_idv;
      logic [31:0] e_pc;
      logic        e_exc;
   } vec_t;

   mreq_t       mq[$];
   vec_t        tbl[12];
   int          lat, cyc, nchecks, nerr, nfires, npops, p0, f0;
   logic        track;
   logic [31:0] exp_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_A5A5;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive this cycle's inputs; memory answers the oldest request once due.
   task automatic go(input logic rv, input logic [31:0] rpc, input logic rdy);
      redirect_valid = rv;
      redirect_pc    = rpc;
      id_ready       = rdy;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(mq[0].addr);
      end
      #1;
   endtask

   task automatic adv();
      mreq_t m;
      if (imem_req_valid && imem_req_ready) begin
         m.addr = imem_req_addr;
         m.due  = cyc + lat;
         mq.push_back(m);
         nfires++;
      end
      if (imem_rsp_valid) m = mq.pop_front();
      if (id_valid && id_ready) begin
         npops++;
         if (track) begin
            chk("pop_pc", id_pc, exp_pc);
            chk("pop_instr", id_instr, mem_word(exp_pc));
            chk("pop_pc4", id_pc4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic reset_dut(input logic do_chk);
      reset          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      id_ready       = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      mq.delete();
      track = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      if (do_chk) begin
         chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
         chk("rst_req_addr", imem_req_addr, 32'h3000);
         chk("rst_id_valid", 32'(id_valid), 32'h0);
         chk("rst_exc", 32'(id_exc_adel), 32'h0);
      end
      reset = 1'b1;
      cyc   = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      nchecks = 0; nerr = 0; nfires = 0; npops = 0; cyc = 0; lat = 1;
      track = 1'b0; exp_pc = 32'h0;

      //            rv    rpc           rdy   req   addr          idv   pc            exc
      tbl[0]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h3000,     1'b0, 32'h0,        1'b0};
      tbl[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h3004,     1'b0, 32'h0,        1'b0};
      tbl[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h3008,     1'b1, 32'h3000,     1'b0};
      tbl[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h300C,     1'b1, 32'h3004,     1'b0};
      tbl[4]  = '{1'b1, 32'h4002,     1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
      tbl[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h4002,     1'b1};
      tbl[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
      tbl[7]  = '{1'b1, 32'h5000,     1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
      tbl[8]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h5000,     1'b0, 32'h0,        1'b0};
      tbl[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h5004,     1'b0, 32'h0,        1'b0};
      tbl[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h5008,     1'b1, 32'h5000,     1'b0};
      tbl[11] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h500C,     1'b1, 32'h5004,     1'b0};

      // Stream from reset, misaligned redirect into HALT, aligned redirect out.
      reset_dut(1'b1);
      lat = 1;
      for (int k = 0; k < 12; k++) begin
         go(tbl[k].rv, tbl[k].rpc, tbl[k].rdy);
         chk($sformatf("v%0d_req_valid", k), 32'(imem_req_valid), 32'(tbl[k].e_req));
         if (tbl[k].e_req) chk($sformatf("v%0d_req_addr", k), imem_req_addr, tbl[k].e_addr);
         chk($sformatf("v%0d_id_valid", k), 32'(id_valid), 32'(tbl[k].e_idv));
         if (tbl[k].e_idv) begin
            chk($sformatf("v%0d_id_pc", k), id_pc, tbl[k].e_pc);
            chk($sformatf("v%0d_id_pc4", k), id_pc4, tbl[k].e_pc + 32'd4);
            chk($sformatf("v%0d_exc", k), 32'(id_exc_adel), 32'(tbl[k].e_exc));
            chk($sformatf("v%0d_instr", k), id_instr,
                tbl[k].e_exc ? 32'h0 : mem_word(tbl[k].e_pc));
         end
         adv();
      end

      // Backpressure: credits cap issue at BUF_DEPTH, order kept on resume.
      reset_dut(1'b0);
      lat = 1; track = 1'b1; exp_pc = 32'h3000; f0 = nfires;
      for (int i = 0; i < 10; i++) begin go(1'b0, 32'h0, 1'b0); adv(); end
      chk("stall_fires", 32'(nfires - f0), 32'd4);
      go(1'b0, 32'h0, 1'b0);
      chk("stall_req_valid", 32'(imem_req_valid), 32'h0);
      chk("stall_id_valid", 32'(id_valid), 32'h1);
      chk("stall_head_pc", id_pc, 32'h3000);
      adv();
      p0 = npops;
      for (int i = 0; i < 12; i++) begin go(1'b0, 32'h0, 1'b1); adv(); end
      chk("resume_pops", 32'(npops - p0), 32'd12);

      // 3-cycle memory, redirect with two responses in flight.
      reset_dut(1'b0);
      lat = 3;
      go(1'b0, 32'h0, 1'b1);
      chk("lat3_req0", imem_req_addr, 32'h3000);
      adv();
      go(1'b0, 32'h0, 1'b1);
      chk("lat3_req1", imem_req_addr, 32'h3004);
      adv();
      go(1'b1, 32'h4000, 1'b1);
      chk("lat3_redir_req_valid", 32'(imem_req_valid), 32'h0);
      adv();
      track = 1'b1; exp_pc = 32'h4000; p0 = npops;
      go(1'b0, 32'h0, 1'b1);
      chk("lat3_new_req_valid", 32'(imem_req_valid), 32'h1);
      chk("lat3_new_req_addr", imem_req_addr, 32'h4000);
      adv();
      for (int i = 0; i < 10; i++) begin go(1'b0, 32'h0, 1'b1); adv(); end
      chk("lat3_popped", 32'(npops > p0), 32'h1);

      // Redirect coinciding with a response and a ready decode.
      reset_dut(1'b0);
      lat = 1; track = 1'b1; exp_pc = 32'h3000;
      for (int i = 0; i < 5; i++) begin go(1'b0, 32'h0, 1'b1); adv(); end
      go(1'b1, 32'h6000, 1'b1);
      chk("coin_id_valid", 32'(id_valid), 32'h0);
      chk("coin_req_valid", 32'(imem_req_valid), 32'h0);
      p0 = npops;
      adv();
      chk("coin_no_pop", 32'(npops - p0), 32'h0);
      exp_pc = 32'h6000;
      go(1'b0, 32'h0, 1'b1);
      chk("coin_req_addr", imem_req_addr, 32'h6000);
      chk("coin_flushed", 32'(id_valid), 32'h0);
      adv();
      go(1'b0, 32'h0, 1'b1);
      chk("coin_dropped", 32'(id_valid), 32'h0);
      adv();
      go(1'b0, 32'h0, 1'b1);
      chk("coin_first_valid", 32'(id_valid), 32'h1);
      chk("coin_first_pc", id_pc, 32'h6000);
      adv();

      // PC wrap at the top of the address space.
      reset_dut(1'b0);
      lat = 1;
      go(1'b1, 32'hFFFF_FFFC, 1'b1); adv();
      go(1'b0, 32'h0, 1'b1);
      chk("wrap_req0", imem_req_addr, 32'hFFFF_FFFC);
      adv();
      go(1'b0, 32'h0, 1'b1);
      chk("wrap_req1", imem_req_addr, 32'h0000_0000);
      adv();
      go(1'b0, 32'h0, 1'b1);
      chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
      chk("wrap_id_pc4", id_pc4, 32'h0000_0000);
      adv();
      go(1'b0, 32'h0, 1'b1);
      chk("wrap_next_pc", id_pc, 32'h0000_0000);
      adv();

      // Asynchronous reset mid-stream with two requests outstanding.
      reset_dut(1'b0);
      lat = 3;
      for (int i = 0; i < 5; i++) begin go(1'b0, 32'h0, 1'b0); adv(); end
      go(1'b0, 32'h0, 1'b0);
      chk("pre_rst_id_valid", 32'(id_valid), 32'h1);
      reset = 1'b0;
      imem_rsp_valid = 1'b0;
      mq.delete();
      #1;
      chk("mid_rst_req_valid", 32'(imem_req_valid), 32'h0);
      chk("mid_rst_req_addr", imem_req_addr, 32'h3000);
      chk("mid_rst_id_valid", 32'(id_valid), 32'h0);
      chk("mid_rst_exc", 32'(id_exc_adel), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1; cyc = 0; lat = 1; track = 1'b1; exp_pc = 32'h3000; p0 = npops;
      go(1'b0, 32'h0, 1'b1);
      chk("post_rst_req_valid", 32'(imem_req_valid), 32'h1);
      chk("post_rst_req_addr", imem_req_addr, 32'h3000);
      adv();
      for (int i = 0; i < 6; i++) begin go(1'b0, 32'h0, 1'b1); adv(); end
      chk("post_rst_pops", 32'(npops - p0), 32'd5);

      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

endmodule
